// File: rtl/apb_arb_pkg.sv
// ---------------------------------------------------------------------------
// apb_arb_pkg
// Shared types and helpers for the APB round-robin arbiter.
//   arb_state_e        : transfer sequencer states (IDLE / SETUP / ACCESS)
//   TIMEOUT_CYCLES_DEF : default ACCESS-phase watchdog limit
//   idx_w()            : width of a binary master index, never less than 1
// ---------------------------------------------------------------------------
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } arb_state_e;

  localparam int TIMEOUT_CYCLES_DEF = 64;

  // A single master still needs a 1-bit index port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// ---------------------------------------------------------------------------
// apb_rr_pick
// Combinational rotating-priority picker. Searches elig_i upward starting at
// ptr_i, wrapping from N-1 to 0, and reports the first set bit.
// Ports:
//   elig_i   [N-1:0]  eligible request vector
//   ptr_i    [IW-1:0] search start index (always < N)
//   any_o             at least one eligible request
//   onehot_o [N-1:0]  one-hot winner (zero when any_o=0)
//   idx_o    [IW-1:0] binary winner index (zero when any_o=0)
// ---------------------------------------------------------------------------
module apb_rr_pick
  import apb_arb_pkg::*;
#(
  parameter int  N  = 9,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] ptr_i,
  output logic          any_o,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o
);

  logic [N-1:0] w_rot;
  logic [IW:0]  w_off;
  logic [IW:0]  w_raw;
  logic [IW:0]  w_sum;

  // Rotate so that bit 0 of w_rot corresponds to elig_i[ptr_i].
  assign w_rot = N'({elig_i, elig_i} >> ptr_i);
  assign any_o = |w_rot;

  // Lowest set bit of the rotated vector = distance from ptr_i to the winner.
  always_comb begin
    w_off = {(IW+1){1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = (IW+1)'(i);
      end else begin
        w_off = w_off;
      end
    end
  end

  assign w_raw = {1'b0, ptr_i} + w_off;

  // Undo the rotation: winner = (ptr_i + offset) mod N.
  always_comb begin
    if (w_raw >= (IW+1)'(N)) begin
      w_sum = w_raw - (IW+1)'(N);
    end else begin
      w_sum = w_raw;
    end
  end

  assign idx_o    = any_o ? IW'(w_sum) : {IW{1'b0}};
  assign onehot_o = any_o ? (N'(1'b1) << idx_o) : {N{1'b0}};

endmodule

// File: rtl/apb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// apb_rr_arbiter
// Round-robin arbiter and transfer sequencer for an N-master to 1-slave APB
// mux. Grants one master at a time, drives slave PSEL/PENABLE through SETUP
// and ACCESS, and holds the grant until the slave returns PREADY.
// Optional build macro: APB_ARB_TIMEOUT_EN adds an ACCESS-phase watchdog.
// Ports:
//   PCLK         clock, all state on rising edge
//   PRESET       asynchronous active-high reset
//   req_i        per-master PSEL, bit i = master i
//   pready_m_i   PREADY from slave
//   gnt_o        one-hot grant, zero when idle
//   gnt_idx_o    binary index of granted master (zero when idle)
//   gnt_vld_o    grant active (SETUP or ACCESS)
//   psel_m_o     PSEL to slave
//   penable_m_o  PENABLE to slave
//   done_o       one-cycle pulse after a completed transfer
//   timeout_o    one-cycle watchdog abort pulse (0 without APB_ARB_TIMEOUT_EN)
// ---------------------------------------------------------------------------
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int  NUM_APB_MASTERS = 9,
  parameter int  TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF,
  localparam int IDX_W           = idx_w(NUM_APB_MASTERS)
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic [NUM_APB_MASTERS-1:0] req_i,
  input  logic                       pready_m_i,
  output logic [NUM_APB_MASTERS-1:0] gnt_o,
  output logic [IDX_W-1:0]           gnt_idx_o,
  output logic                       gnt_vld_o,
  output logic                       psel_m_o,
  output logic                       penable_m_o,
  output logic                       done_o,
  output logic                       timeout_o
);

  arb_state_e                 r_state, w_state;
  logic [NUM_APB_MASTERS-1:0] r_gnt, w_gnt;
  logic [IDX_W-1:0]           r_gnt_idx, w_gnt_idx;
  logic                       r_gnt_vld, w_gnt_vld;
  logic                       r_psel, w_psel;
  logic                       r_penable, w_penable;
  logic                       r_done, w_done;
  logic [IDX_W-1:0]           r_rr_ptr, w_rr_ptr;
  logic [NUM_APB_MASTERS-1:0] r_last_mask, w_last_mask;

  logic [NUM_APB_MASTERS-1:0] w_elig;
  logic                       w_pick_any;
  logic [NUM_APB_MASTERS-1:0] w_pick_oh;
  logic [IDX_W-1:0]           w_pick_idx;
  logic [IDX_W-1:0]           w_ptr_adv;
  logic                       w_own_req;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCNT_W-1:0] r_tcnt, w_tcnt;
  logic              r_timeout, w_timeout;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  // The master that just finished usually still shows PSEL for one cycle.
  assign w_elig    = req_i & ~r_last_mask;
  assign w_own_req = |(req_i & r_gnt);
  assign w_ptr_adv = (r_gnt_idx == IDX_W'(NUM_APB_MASTERS - 1)) ? {IDX_W{1'b0}}
                                                               : r_gnt_idx + IDX_W'(1'b1);

  apb_rr_pick #(
    .N (NUM_APB_MASTERS)
  ) u_pick (
    .elig_i   (w_elig),
    .ptr_i    (r_rr_ptr),
    .any_o    (w_pick_any),
    .onehot_o (w_pick_oh),
    .idx_o    (w_pick_idx)
  );

  // Next-state and next-output logic for the IDLE/SETUP/ACCESS sequencer.
  always_comb begin
    w_state     = r_state;
    w_gnt       = r_gnt;
    w_gnt_idx   = r_gnt_idx;
    w_gnt_vld   = r_gnt_vld;
    w_psel      = r_psel;
    w_penable   = r_penable;
    w_done      = 1'b0;
    w_rr_ptr    = r_rr_ptr;
    w_last_mask = r_last_mask;
`ifdef APB_ARB_TIMEOUT_EN
    w_timeout   = 1'b0;
    w_tcnt      = {TCNT_W{1'b0}};
`endif
    case (r_state)
      IDLE: begin
        w_last_mask = {NUM_APB_MASTERS{1'b0}};
        if (w_pick_any) begin
          w_gnt     = w_pick_oh;
          w_gnt_idx = w_pick_idx;
          w_gnt_vld = 1'b1;
          w_psel    = 1'b1;
          w_penable = 1'b0;
          w_state   = SETUP;
        end else begin
          w_gnt     = {NUM_APB_MASTERS{1'b0}};
          w_gnt_idx = {IDX_W{1'b0}};
          w_gnt_vld = 1'b0;
          w_psel    = 1'b0;
          w_penable = 1'b0;
        end
      end
      SETUP: begin
        if (w_own_req) begin
          w_penable = 1'b1;
          w_state   = ACCESS;
        end else begin
          // Granted master withdrew PSEL: abort without crediting it.
          w_gnt     = {NUM_APB_MASTERS{1'b0}};
          w_gnt_idx = {IDX_W{1'b0}};
          w_gnt_vld = 1'b0;
          w_psel    = 1'b0;
          w_penable = 1'b0;
          w_state   = IDLE;
        end
      end
      ACCESS: begin
        if (!w_own_req) begin
          w_gnt     = {NUM_APB_MASTERS{1'b0}};
          w_gnt_idx = {IDX_W{1'b0}};
          w_gnt_vld = 1'b0;
          w_psel    = 1'b0;
          w_penable = 1'b0;
          w_state   = IDLE;
        end else if (pready_m_i) begin
          w_done      = 1'b1;
          w_rr_ptr    = w_ptr_adv;
          w_last_mask = r_gnt;
          w_gnt       = {NUM_APB_MASTERS{1'b0}};
          w_gnt_idx   = {IDX_W{1'b0}};
          w_gnt_vld   = 1'b0;
          w_psel      = 1'b0;
          w_penable   = 1'b0;
          w_state     = IDLE;
        end else begin
`ifdef APB_ARB_TIMEOUT_EN
          if (r_tcnt == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
            // Stalled slave: drop the transfer and move past this master.
            w_timeout   = 1'b1;
            w_rr_ptr    = w_ptr_adv;
            w_last_mask = r_gnt;
            w_gnt       = {NUM_APB_MASTERS{1'b0}};
            w_gnt_idx   = {IDX_W{1'b0}};
            w_gnt_vld   = 1'b0;
            w_psel      = 1'b0;
            w_penable   = 1'b0;
            w_state     = IDLE;
          end else begin
            w_tcnt  = r_tcnt + TCNT_W'(1'b1);
            w_state = ACCESS;
          end
`else
          w_state = ACCESS;
`endif
        end
      end
      default: begin
        w_gnt     = {NUM_APB_MASTERS{1'b0}};
        w_gnt_idx = {IDX_W{1'b0}};
        w_gnt_vld = 1'b0;
        w_psel    = 1'b0;
        w_penable = 1'b0;
        w_state   = IDLE;
      end
    endcase
  end

  // State, grant and pointer registers.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state     <= IDLE;
      r_gnt       <= {NUM_APB_MASTERS{1'b0}};
      r_gnt_idx   <= {IDX_W{1'b0}};
      r_gnt_vld   <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_done      <= 1'b0;
      r_rr_ptr    <= {IDX_W{1'b0}};
      r_last_mask <= {NUM_APB_MASTERS{1'b0}};
    end else begin
      r_state     <= w_state;
      r_gnt       <= w_gnt;
      r_gnt_idx   <= w_gnt_idx;
      r_gnt_vld   <= w_gnt_vld;
      r_psel      <= w_psel;
      r_penable   <= w_penable;
      r_done      <= w_done;
      r_rr_ptr    <= w_rr_ptr;
      r_last_mask <= w_last_mask;
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  // ACCESS-phase watchdog counter and its abort pulse.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_tcnt    <= {TCNT_W{1'b0}};
      r_timeout <= 1'b0;
    end else begin
      r_tcnt    <= w_tcnt;
      r_timeout <= w_timeout;
    end
  end

  assign timeout_o = r_timeout;
`else
  assign timeout_o = 1'b0;
`endif

  assign gnt_o       = r_gnt;
  assign gnt_idx_o   = r_gnt_idx;
  assign gnt_vld_o   = r_gnt_vld;
  assign psel_m_o    = r_psel;
  assign penable_m_o = r_penable;
  assign done_o      = r_done;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_rr_arbiter
// Directed self-checking bench for apb_rr_arbiter (9 masters, watchdog limit
// 8 when APB_ARB_TIMEOUT_EN is defined). Inputs change 1 time unit after the
// rising edge; outputs are compared at the same point.
// ---------------------------------------------------------------------------
module tb_apb_rr_arbiter;

  localparam int N  = 9;
  localparam int IW = 4;
  localparam int SW = N + IW + 5;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic [N-1:0]  req_i = '0;
  logic          pready_m_i = 1'b0;
  logic [N-1:0]  gnt_o;
  logic [IW-1:0] gnt_idx_o;
  logic          gnt_vld_o;
  logic          psel_m_o;
  logic          penable_m_o;
  logic          done_o;
  logic          timeout_o;

  logic [SW-1:0] obs;
  int n_checks = 0;
  int n_pass   = 0;

  always #5 PCLK = ~PCLK;

  apb_rr_arbiter #(
    .NUM_APB_MASTERS (N),
    .TIMEOUT_CYCLES  (8)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .req_i       (req_i),
    .pready_m_i  (pready_m_i),
    .gnt_o       (gnt_o),
    .gnt_idx_o   (gnt_idx_o),
    .gnt_vld_o   (gnt_vld_o),
    .psel_m_o    (psel_m_o),
    .penable_m_o (penable_m_o),
    .done_o      (done_o),
    .timeout_o   (timeout_o)
  );

  assign obs = {gnt_o, gnt_idx_o, gnt_vld_o, psel_m_o, penable_m_o, done_o, timeout_o};

  // Packs an expected output vector in the same order as obs.
  function automatic logic [SW-1:0] ex(input logic [N-1:0] g, input logic [IW-1:0] ix,
                                       input logic v, input logic p, input logic e,
                                       input logic d, input logic t);
    return {g, ix, v, p, e, d, t};
  endfunction

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic do_reset();
    PRESET = 1'b1;
    req_i = '0;
    pready_m_i = 1'b0;
    tick();
    tick();
    PRESET = 1'b0;
  endtask

  task automatic test_reset();
    logic [SW-1:0] e;
    e = '0;
    PRESET = 1'b1;
    req_i = 9'h1FF;
    tick();
    n_checks++;
    if (obs !== e) $display("FAIL reset_hold: got %h need %h", obs, e); else n_pass++;
    tick();
    PRESET = 1'b0;
    req_i = '0;
    tick();
    n_checks++;
    if (obs !== e) $display("FAIL reset_idle: got %h need %h", obs, e); else n_pass++;
  endtask

  task automatic test_single();
    logic [SW-1:0] e;
    req_i = 9'h001;
    pready_m_i = 1'b0;
    tick();
    e = ex(9'h001, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== e) $display("FAIL single_setup: got %h need %h", obs, e); else n_pass++;
    tick();
    e = ex(9'h001, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (obs !== e) $display("FAIL single_access: got %h need %h", obs, e); else n_pass++;
    pready_m_i = 1'b1;
    tick();
    e = ex(9'h000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs !== e) $display("FAIL single_done: got %h need %h", obs, e); else n_pass++;
    req_i = '0;
    pready_m_i = 1'b0;
    tick();
    e = '0;
    n_checks++;
    if (obs !== e) $display("FAIL single_idle: got %h need %h", obs, e); else n_pass++;
    // Pointer moved to 1, so with masters 0 and 1 requesting, 1 wins.
    req_i = 9'h003;
    tick();
    e = ex(9'h002, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== e) $display("FAIL single_ptr: got %h need %h", obs, e); else n_pass++;
    pready_m_i = 1'b1;
    tick();
    tick();
    req_i = '0;
    pready_m_i = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [SW-1:0] e;
    logic [N-1:0]  oh;
    do_reset();
    req_i = 9'h007;
    pready_m_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      oh = 9'h001 << k;
      tick();
      e = ex(oh, 4'(k), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obs !== e) $display("FAIL rr_grant%0d: got %h need %h", k, obs, e); else n_pass++;
      tick();
      e = ex(oh, 4'(k), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (obs !== e) $display("FAIL rr_access%0d: got %h need %h", k, obs, e); else n_pass++;
      tick();
      e = ex(9'h000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (obs !== e) $display("FAIL rr_done%0d: got %h need %h", k, obs, e); else n_pass++;
    end
    tick();
    e = ex(9'h001, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== e) $display("FAIL rr_wrap: got %h need %h", obs, e); else n_pass++;
    // Withdraw the request during SETUP: abort, no done pulse.
    req_i = '0;
    tick();
    e = '0;
    n_checks++;
    if (obs !== e) $display("FAIL rr_setup_drop: got %h need %h", obs, e); else n_pass++;
    pready_m_i = 1'b0;
    tick();
  endtask

  task automatic test_ptr5();
    logic [SW-1:0] e;
    logic [N-1:0]  oh;
    int order [3] = '{7, 8, 4};
    do_reset();
    req_i = 9'h010;
    pready_m_i = 1'b1;
    tick();
    e = ex(9'h010, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== e) $display("FAIL p5_setup4: got %h need %h", obs, e); else n_pass++;
    tick();
    tick();
    req_i = 9'h190;
    for (int k = 0; k < 3; k++) begin
      oh = 9'h001 << order[k];
      tick();
      e = ex(oh, 4'(order[k]), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obs !== e) $display("FAIL p5_grant%0d: got %h need %h", order[k], obs, e); else n_pass++;
      tick();
      tick();
      e = ex(9'h000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (obs !== e) $display("FAIL p5_done%0d: got %h need %h", order[k], obs, e); else n_pass++;
    end
    req_i = '0;
    pready_m_i = 1'b0;
    tick();
  endtask

  task automatic test_last_mask();
    logic [SW-1:0] e;
    do_reset();
    req_i = 9'h008;
    pready_m_i = 1'b1;
    tick();
    tick();
    tick();
    e = ex(9'h000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs !== e) $display("FAIL lm_done: got %h need %h", obs, e); else n_pass++;
    tick();
    e = '0;
    n_checks++;
    if (obs !== e) $display("FAIL lm_blocked: got %h need %h", obs, e); else n_pass++;
    req_i = '0;
    tick();
    n_checks++;
    if (obs !== e) $display("FAIL lm_idle: got %h need %h", obs, e); else n_pass++;
    req_i = 9'h008;
    tick();
    e = ex(9'h008, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== e) $display("FAIL lm_regrant: got %h need %h", obs, e); else n_pass++;
    tick();
    tick();
    req_i = '0;
    pready_m_i = 1'b0;
    tick();
  endtask

  task automatic test_drop();
    logic [SW-1:0] e;
    do_reset();
    req_i = 9'h006;
    pready_m_i = 1'b0;
    tick();
    tick();
    tick();
    e = ex(9'h002, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (obs !== e) $display("FAIL drop_wait: got %h need %h", obs, e); else n_pass++;
    req_i = 9'h004;
    tick();
    e = '0;
    n_checks++;
    if (obs !== e) $display("FAIL drop_abort: got %h need %h", obs, e); else n_pass++;
    // Pointer still 0: master 1 beats master 3.
    req_i = 9'h00A;
    tick();
    e = ex(9'h002, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== e) $display("FAIL drop_ptr: got %h need %h", obs, e); else n_pass++;
    pready_m_i = 1'b1;
    tick();
    tick();
    req_i = '0;
    pready_m_i = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    logic [SW-1:0] e;
    do_reset();
    req_i = 9'h001;
    pready_m_i = 1'b0;
    tick();
    tick();
    e = ex(9'h001, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (obs !== e) $display("FAIL ar_access: got %h need %h", obs, e); else n_pass++;
    #2;
    PRESET = 1'b1;
    #1;
    e = '0;
    n_checks++;
    if (obs !== e) $display("FAIL ar_async: got %h need %h", obs, e); else n_pass++;
    tick();
    n_checks++;
    if (obs !== e) $display("FAIL ar_no_done: got %h need %h", obs, e); else n_pass++;
    req_i = '0;
    PRESET = 1'b0;
    tick();
  endtask

`ifdef APB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [SW-1:0] e;
    do_reset();
    req_i = 9'h003;
    pready_m_i = 1'b0;
    tick();
    tick();
    e = ex(9'h001, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k < 8; k++) begin
      tick();
      n_checks++;
      if (obs !== e) $display("FAIL to_wait%0d: got %h need %h", k, obs, e); else n_pass++;
    end
    tick();
    e = ex(9'h000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (obs !== e) $display("FAIL to_pulse: got %h need %h", obs, e); else n_pass++;
    tick();
    e = ex(9'h002, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== e) $display("FAIL to_next: got %h need %h", obs, e); else n_pass++;
    do_reset();
  endtask
`else
  task automatic test_wait_unbounded();
    logic [SW-1:0] e;
    do_reset();
    req_i = 9'h001;
    pready_m_i = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 12; k++) begin
      tick();
    end
    e = ex(9'h001, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (obs !== e) $display("FAIL wait_hold: got %h need %h", obs, e); else n_pass++;
    pready_m_i = 1'b1;
    tick();
    e = ex(9'h000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs !== e) $display("FAIL wait_done: got %h need %h", obs, e); else n_pass++;
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_ptr5();
    test_last_mask();
    test_drop();
    test_async_reset();
`ifdef APB_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_wait_unbounded();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
